control_seq: RTL
================

// Module: control_seq
// PURPOSE
// Clocked, parametrised successor to the single-cycle decoder: sequences program execution from a req/done handshake.
// Decodes the opcode field of each fetched instruction into datapath enables.
// Inserts MEM_LAT wait states on data-memory loads, flags reserved opcodes and counts cycles and retired instructions.
// Sits between instruction ROM / PC and the datapath (regfile, accumulator, ALU, data memory).
// PARAMETERS
// INSTR_W  9   instruction width; opcode = instruction[INSTR_W-1 -: OP_W]
// OP_W     5   opcode field width; must be >= 5
// MEM_LAT  1   extra wait cycles for loadm (0 = single-cycle load); 0..15
// CNT_W    16  width of cycle_count and instr_count
// PORTS
// clk               in   1        system clock, all state on rising edge
// rst_n             in   1        synchronous active-low reset
// req               in   1        start/restart program (level, sampled each cycle)
// instruction       in   INSTR_W  instruction at current PC
// alu_op            out  OP_W     opcode field, passed through unconditionally
// reg_write_enable  out  1        regfile write (storev)
// acc_write_enable  out  1        accumulator write
// dat_write_enable  out  1        data-memory write (storem)
// mem_read_enable   out  1        data-memory read strobe (loadm)
// compare_enable    out  1        qualify branch with compare (beq)
// reljump_enable    out  1        PC relative jump
// absjump_enable    out  1        PC absolute jump
// acc_src           out  1        0 = memory data, 1 = ALU result
// pc_reset          out  1        PC to 0
// pc_enable         out  1        PC advances/jumps this cycle
// done              out  1        1 when not running (IDLE or HALT)
// illegal_op        out  1        sticky: reserved opcode executed this run
// cycle_count       out  CNT_W    cycles spent in EXEC/MEMW this run, saturating
// instr_count       out  CNT_W    instructions retired this run, saturating
// BEHAVIOUR
// States: IDLE, PCRST, EXEC, MEMW, HALT. Reset -> IDLE, wait counter 0, counters 0, illegal_op 0.
// Outputs are combinational from state and instruction; all enables 0 unless listed.
// Reset values: done=1, acc_src=1, every other output 0 (alu_op follows instruction).
// IDLE/HALT: done=1. If req=1 -> PCRST.
// PCRST: pc_reset=1, done=0, counters and illegal_op cleared.
//   If req=1 stay in PCRST, else -> EXEC.
// EXEC: done=0. If req=1 (restart): all enables 0, pc_reset=1, counters cleared, -> PCRST. req has priority over any op.
// EXEC decode (pc_enable=1 unless noted):
//   0-16 ALU: acc_write=1.
//   17 loadm: mem_read=1, acc_src=0.
//     MEM_LAT=0: acc_write=1, stay in EXEC.
//     MEM_LAT>0: pc_enable=0, acc_write=0, -> MEMW.
//   18 loadv / 21 slt: acc_write=1.
//   19 storem: dat_write=1.
//   20 storev: reg_write=1.
//   22 beq: compare=1, reljump=1.
//   23 rb: reljump=1.
//   24 ab: absjump=1.
//   25-30 reserved: executed as nop (pc_enable=1 only), sets illegal_op.
//   31 done: pc_enable=0, all enables 0, -> HALT next cycle.
// MEMW: mem_read=1, acc_src=0, pc_enable=0, wait counter counts up.
//   On wait-count == MEM_LAT-1: acc_write=1, pc_enable=1, -> EXEC.
//   Total loadm latency = 1+MEM_LAT cycles. req in MEMW aborts as in EXEC (no acc_write).
// instr_count: +1 on each retiring cycle (pc_enable=1, or done op in EXEC).
// cycle_count: +1 every EXEC/MEMW cycle. Both saturate at all-ones, no wrap.
// Counters and illegal_op hold their values in HALT until the next PCRST.
// STRUCTURE
// control_pkg: state_t enum, OP_* opcode localparams (OP_LOADM=17 ... OP_DONE=31), op_class function.
// Sub-module sat_counter #(CNT_W) (clr, inc -> q), instantiated twice. Decode stays inline.
// TESTING
// 1 Reset: rst_n=0 two cycles -> done=1, pc_enable=0, counters 0. req pulse -> 1 cycle pc_reset=1, then EXEC.
// 2 Program ALU(op 3), storem(19), done(31), MEM_LAT=1 -> acc_write, then dat_write.
//   done=1 on cycle 4 after PCRST; instr_count=3, cycle_count=3.
// 3 loadm with MEM_LAT=3 -> pc_enable low 3 cycles, mem_read high 4 cycles, acc_write only on 4th, acc_src=0 throughout.
// 4 req asserted during MEMW -> no acc_write; PCRST next cycle; counters cleared; run restarts from PC 0.
// 5 opcode 27 -> behaves as nop, illegal_op=1 sticky through HALT, cleared by next req.
// 6 CNT_W=4, 20-instruction ALU loop -> cycle_count saturates at 15, no wrap; beq emits compare+reljump same cycle.

Source files
------------

// File: rtl/control_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : control_seq_pkg
// Brief    : Shared types for the control sequencer: FSM states, opcode
//            values and the opcode classifier used by the decoder.
// Revision : 1.0 - initial release
// ============================================================================
package control_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PCRST = 3'd1,
    ST_EXEC  = 3'd2,
    ST_MEMW  = 3'd3,
    ST_HALT  = 3'd4
  } state_t;

  localparam logic [4:0] OP_ALU_MAX = 5'd16;
  localparam logic [4:0] OP_LOADM   = 5'd17;
  localparam logic [4:0] OP_LOADV   = 5'd18;
  localparam logic [4:0] OP_STOREM  = 5'd19;
  localparam logic [4:0] OP_STOREV  = 5'd20;
  localparam logic [4:0] OP_SLT     = 5'd21;
  localparam logic [4:0] OP_BEQ     = 5'd22;
  localparam logic [4:0] OP_RB      = 5'd23;
  localparam logic [4:0] OP_AB      = 5'd24;
  localparam logic [4:0] OP_DONE    = 5'd31;

  // Behavioural groups: opcodes within a class drive identical enables
  typedef enum logic [3:0] {
    CL_ACC    = 4'd0,   // ALU ops, loadv, slt: accumulator write
    CL_LOADM  = 4'd1,
    CL_STOREM = 4'd2,
    CL_STOREV = 4'd3,
    CL_BEQ    = 4'd4,
    CL_RB     = 4'd5,
    CL_AB     = 4'd6,
    CL_RSVD   = 4'd7,
    CL_DONE   = 4'd8
  } op_class_t;

  // Map an opcode onto its class; any set bit above the 5-bit range is reserved
  function automatic op_class_t op_class(input logic [4:0] op, input logic hi_nz);
    op_class_t cls;
    cls = CL_RSVD;
    if (!hi_nz) begin
      if (op <= OP_ALU_MAX) begin
        cls = CL_ACC;
      end else begin
        case (op)
          OP_LOADM:        cls = CL_LOADM;
          OP_LOADV, OP_SLT: cls = CL_ACC;
          OP_STOREM:       cls = CL_STOREM;
          OP_STOREV:       cls = CL_STOREV;
          OP_BEQ:          cls = CL_BEQ;
          OP_RB:           cls = CL_RB;
          OP_AB:           cls = CL_AB;
          OP_DONE:         cls = CL_DONE;
          default:         cls = CL_RSVD;
        endcase
      end
    end
    return cls;
  endfunction

endpackage
`default_nettype wire

// File: rtl/control_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : control_seq_if
// Brief    : Handshake / decode bundle between program source and the
//            control sequencer. The master drives req and instruction.
// Revision : 1.0 - initial release
// ============================================================================
interface control_seq_if #(
  parameter int INSTR_W = 9,
  parameter int OP_W    = 5,
  parameter int CNT_W   = 16
);
  logic               req;
  logic [INSTR_W-1:0] instruction;
  logic [OP_W-1:0]    alu_op;
  logic               reg_write_enable;
  logic               acc_write_enable;
  logic               dat_write_enable;
  logic               mem_read_enable;
  logic               compare_enable;
  logic               reljump_enable;
  logic               absjump_enable;
  logic               acc_src;
  logic               pc_reset;
  logic               pc_enable;
  logic               done;
  logic               illegal_op;
  logic [CNT_W-1:0]   cycle_count;
  logic [CNT_W-1:0]   instr_count;

  modport master (
    output req, instruction,
    input  alu_op, reg_write_enable, acc_write_enable, dat_write_enable,
           mem_read_enable, compare_enable, reljump_enable, absjump_enable,
           acc_src, pc_reset, pc_enable, done, illegal_op, cycle_count, instr_count
  );

  modport slave (
    input  req, instruction,
    output alu_op, reg_write_enable, acc_write_enable, dat_write_enable,
           mem_read_enable, compare_enable, reljump_enable, absjump_enable,
           acc_src, pc_reset, pc_enable, done, illegal_op, cycle_count, instr_count
  );
endinterface
`default_nettype wire

// File: rtl/control_seq_sat_counter.sv
`default_nettype none
// ============================================================================
// Module   : sat_counter
// Brief    : Up-counter with synchronous clear that sticks at all-ones.
// Revision : 1.0 - initial release
// ============================================================================
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  input  wire logic             clr_i,
  input  wire logic             inc_i,
  output logic [CNT_W-1:0]      q_o
);

  logic [CNT_W-1:0] cnt_q;

  // Clear wins over increment; increment stops at all-ones
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (inc_i && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign q_o = cnt_q;

endmodule
`default_nettype wire

// File: rtl/control_seq.sv
`default_nettype none
// ============================================================================
// Module   : control_seq
// Brief    : Clocked program sequencer. Decodes the opcode of the current
//            instruction into datapath enables, stretches loadm by MEM_LAT
//            wait states, flags reserved opcodes and counts cycles and
//            retired instructions per run.
// Revision : 1.0 - initial release
// ============================================================================
module control_seq
  import control_seq_pkg::*;
#(
  parameter int INSTR_W = 9,
  parameter int OP_W    = 5,
  parameter int MEM_LAT = 1,
  parameter int CNT_W   = 16
) (
  input wire logic      clk,
  input wire logic      rst_n,
  control_seq_if.slave  bus
);

  // Last wait-state index before the load completes (unused when MEM_LAT=0)
  localparam logic [3:0] LAT_LAST = (MEM_LAT > 0) ? 4'(MEM_LAT - 1) : 4'd0;

  state_t      state_q, state_d;
  logic [3:0]  wait_q, wait_d;
  logic        illegal_q, illegal_d;

  logic [OP_W-1:0] opcode;
  logic            op_hi_nz;
  op_class_t       cls;

  logic reg_we, acc_we, dat_we, mem_re, cmp_en, rel_en, abs_en;
  logic acc_src, pc_reset, pc_en, done;
  logic cnt_clr, cyc_inc, ins_inc;

  // Operand bits are consumed by the datapath, not by the sequencer
  logic unused_operand;
  assign unused_operand = ^bus.instruction;

  assign opcode = bus.instruction[INSTR_W-1 -: OP_W];

  if (OP_W > 5) begin : g_op_hi
    assign op_hi_nz = |opcode[OP_W-1:5];
  end else begin : g_op_narrow
    assign op_hi_nz = 1'b0;
  end

  assign cls = op_class(opcode[4:0], op_hi_nz);

  // Next-state and output decode from current state and instruction
  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    illegal_d = illegal_q;
    reg_we    = 1'b0;
    acc_we    = 1'b0;
    dat_we    = 1'b0;
    mem_re    = 1'b0;
    cmp_en    = 1'b0;
    rel_en    = 1'b0;
    abs_en    = 1'b0;
    acc_src   = 1'b1;
    pc_reset  = 1'b0;
    pc_en     = 1'b0;
    done      = 1'b0;
    cnt_clr   = 1'b0;
    cyc_inc   = 1'b0;
    ins_inc   = 1'b0;

    case (state_q)
      ST_IDLE, ST_HALT: begin
        done = 1'b1;
        if (bus.req) state_d = ST_PCRST;
      end

      ST_PCRST: begin
        pc_reset  = 1'b1;
        cnt_clr   = 1'b1;
        illegal_d = 1'b0;
        wait_d    = '0;
        if (!bus.req) state_d = ST_EXEC;
      end

      ST_EXEC: begin
        if (bus.req) begin
          // Restart beats any opcode: nothing executes this cycle
          pc_reset = 1'b1;
          cnt_clr  = 1'b1;
          state_d  = ST_PCRST;
        end else begin
          cyc_inc = 1'b1;
          pc_en   = 1'b1;
          case (cls)
            CL_ACC:    acc_we = 1'b1;
            CL_LOADM: begin
              mem_re  = 1'b1;
              acc_src = 1'b0;
              if (MEM_LAT == 0) begin
                acc_we = 1'b1;
              end else begin
                pc_en   = 1'b0;
                wait_d  = '0;
                state_d = ST_MEMW;
              end
            end
            CL_STOREM: dat_we = 1'b1;
            CL_STOREV: reg_we = 1'b1;
            CL_BEQ: begin
              cmp_en = 1'b1;
              rel_en = 1'b1;
            end
            CL_RB:     rel_en = 1'b1;
            CL_AB:     abs_en = 1'b1;
            CL_DONE: begin
              pc_en   = 1'b0;
              state_d = ST_HALT;
            end
            default:   illegal_d = 1'b1;
          endcase
          ins_inc = pc_en | (cls == CL_DONE);
        end
      end

      ST_MEMW: begin
        if (bus.req) begin
          pc_reset = 1'b1;
          cnt_clr  = 1'b1;
          wait_d   = '0;
          state_d  = ST_PCRST;
        end else begin
          cyc_inc = 1'b1;
          mem_re  = 1'b1;
          acc_src = 1'b0;
          if (wait_q == LAT_LAST) begin
            acc_we  = 1'b1;
            pc_en   = 1'b1;
            ins_inc = 1'b1;
            wait_d  = '0;
            state_d = ST_EXEC;
          end else begin
            wait_d = wait_q + 4'd1;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
        wait_d  = '0;
      end
    endcase
  end

  // Sequencer state, load wait counter and sticky reserved-opcode flag
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      wait_q    <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      illegal_q <= illegal_d;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_cycle_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (cnt_clr),
    .inc_i (cyc_inc),
    .q_o   (bus.cycle_count)
  );

  sat_counter #(.CNT_W(CNT_W)) u_instr_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (cnt_clr),
    .inc_i (ins_inc),
    .q_o   (bus.instr_count)
  );

  assign bus.alu_op           = opcode;
  assign bus.reg_write_enable = reg_we;
  assign bus.acc_write_enable = acc_we;
  assign bus.dat_write_enable = dat_we;
  assign bus.mem_read_enable  = mem_re;
  assign bus.compare_enable   = cmp_en;
  assign bus.reljump_enable   = rel_en;
  assign bus.absjump_enable   = abs_en;
  assign bus.acc_src          = acc_src;
  assign bus.pc_reset         = pc_reset;
  assign bus.pc_enable        = pc_en;
  assign bus.done             = done;
  assign bus.illegal_op       = illegal_q;

endmodule
`default_nettype wire
